// File: rtl/bf_tape_memory.sv
// Brainfuck data tape: pointer-addressed cell array with SET/ADD/move commands,
// optional pointer wrap-around and a full-tape clear sweep shared with reset init.
module bf_tape_memory #(
    parameter int unsigned CELL_WIDTH = 8,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter bit          WRAP       = 1'b0
) (
    input  logic                  working_clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    input  logic [2:0]            cmd_op,
    input  logic [CELL_WIDTH-1:0] cmd_data,
    output logic                  cmd_ready,
    output logic [CELL_WIDTH-1:0] ptr_value,
    output logic [ADDR_WIDTH-1:0] ptr_address,
    output logic                  ptr_is_zero,
    output logic                  range_error
);

    typedef enum logic [1:0] {StInit, StIdle, StClear} state_e;

    typedef enum logic [2:0] {
        OpNop      = 3'd0,
        OpSet      = 3'd1,
        OpAdd      = 3'd2,
        OpMovr     = 3'd3,
        OpMovl     = 3'd4,
        OpRollback = 3'd5,
        OpClear    = 3'd6,
        OpRsvd     = 3'd7
    } op_e;

    // Wide enough that address + step never overflows before range checking.
    localparam int unsigned            TW       = ADDR_WIDTH + CELL_WIDTH + 1;
    localparam logic [TW-1:0]          DepthExt = TW'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0]  LastAddr = ADDR_WIDTH'(DEPTH - 1);

    state_e                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;

    logic [CELL_WIDTH-1:0]   mem_q [DEPTH];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [CELL_WIDTH-1:0]   mem_wdata;

    logic [TW-1:0]           addr_ext, step_ext, right_sum, left_diff;
    logic [TW-1:0]           step_mod, wrap_right, wrap_left;
    logic                    right_oob, left_oob;
    logic                    accept;

    assign addr_ext   = TW'(addr_q);
    assign step_ext   = TW'(cmd_data);
    assign right_sum  = addr_ext + step_ext;
    assign left_diff  = addr_ext - step_ext;
    assign step_mod   = step_ext % DepthExt;
    assign wrap_right = right_sum % DepthExt;
    assign wrap_left  = (addr_ext + DepthExt - step_mod) % DepthExt;
    assign right_oob  = right_sum >= DepthExt;
    assign left_oob   = step_ext > addr_ext;

    assign accept = cmd_valid && ready_q;

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        err_d     = 1'b0;
        addr_d    = addr_q;
        sweep_d   = sweep_q;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = cmd_data;

        case (state_q)
            StInit, StClear: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_q;
                mem_wdata = '0;
                sweep_d   = sweep_q + 1'b1;
                if (sweep_q == LastAddr) begin
                    state_d = StIdle;
                    ready_d = 1'b1;
                    sweep_d = '0;
                end
            end
            StIdle: begin
                if (accept) begin
                    case (op_e'(cmd_op))
                        OpSet: mem_we = 1'b1;
                        OpAdd: begin
                            mem_we    = 1'b1;
                            mem_wdata = mem_q[addr_q] + cmd_data;
                        end
                        OpMovr: begin
                            if (WRAP) begin
                                addr_d = ADDR_WIDTH'(wrap_right);
                            end else if (right_oob) begin
                                addr_d = LastAddr;
                                err_d  = 1'b1;
                            end else begin
                                addr_d = ADDR_WIDTH'(right_sum);
                            end
                        end
                        OpMovl: begin
                            if (WRAP) begin
                                addr_d = ADDR_WIDTH'(wrap_left);
                            end else if (left_oob) begin
                                addr_d = '0;
                                err_d  = 1'b1;
                            end else begin
                                addr_d = ADDR_WIDTH'(left_diff);
                            end
                        end
                        OpRollback: addr_d = '0;
                        OpClear: begin
                            state_d = StClear;
                            ready_d = 1'b0;
                            addr_d  = '0;
                            sweep_d = '0;
                        end
                        OpRsvd: err_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: begin
                state_d = StInit;
                ready_d = 1'b0;
                sweep_d = '0;
            end
        endcase
    end

    always_ff @(posedge working_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StInit;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            sweep_q <= sweep_d;
        end
    end

    // Cell storage has no reset; the init sweep defines its contents.
    always_ff @(posedge working_clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign cmd_ready   = ready_q;
    assign ptr_address = addr_q;
    assign ptr_value   = mem_q[addr_q];
    assign ptr_is_zero = (ptr_value == '0);
    assign range_error = err_q;

endmodule

// File: tb/tb_bf_tape_memory.sv
// Randomised and directed bench for bf_tape_memory: a clamping DEPTH=64 tape and a
// wrapping DEPTH=48 tape share one command stream and are checked against a tape model.
module tb_bf_tape_memory;

    localparam int D[2] = '{64, 48};
    localparam bit W[2] = '{1'b0, 1'b1};

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;

    logic       rdy [2];
    logic [7:0] val [2];
    logic [5:0] adr [2];
    logic       zr  [2];
    logic       er  [2];

    int checks;
    int errors;

    bf_tape_memory #(
        .CELL_WIDTH (8),
        .DEPTH      (64),
        .ADDR_WIDTH (6),
        .WRAP       (1'b0)
    ) u_clamp (
        .working_clock (clk),
        .reset_n       (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .cmd_ready     (rdy[0]),
        .ptr_value     (val[0]),
        .ptr_address   (adr[0]),
        .ptr_is_zero   (zr[0]),
        .range_error   (er[0])
    );

    bf_tape_memory #(
        .CELL_WIDTH (8),
        .DEPTH      (48),
        .ADDR_WIDTH (6),
        .WRAP       (1'b1)
    ) u_wrap (
        .working_clock (clk),
        .reset_n       (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .cmd_ready     (rdy[1]),
        .ptr_value     (val[1]),
        .ptr_address   (adr[1]),
        .ptr_is_zero   (zr[1]),
        .range_error   (er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural tape model ----------------
    logic [7:0] m_mem  [2][64];
    int         m_addr [2];
    int         m_busy [2];
    bit         m_err  [2];

    task automatic model_reset(input int i);
        for (int c = 0; c < 64; c++) m_mem[i][c] = 8'h00;
        m_addr[i] = 0;
        m_busy[i] = D[i];
        m_err[i]  = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) model_reset(i);
        end else begin
            for (int i = 0; i < 2; i++) begin
                int t;
                m_err[i] = 1'b0;
                if (m_busy[i] > 0) begin
                    m_busy[i]--;
                end else if (cmd_valid) begin
                    case (cmd_op)
                        3'd1: m_mem[i][m_addr[i]] = cmd_data;
                        3'd2: m_mem[i][m_addr[i]] = m_mem[i][m_addr[i]] + cmd_data;
                        3'd3, 3'd4: begin
                            t = (cmd_op == 3'd3) ? m_addr[i] + int'(cmd_data)
                                                 : m_addr[i] - int'(cmd_data);
                            if (W[i]) begin
                                t = ((t % D[i]) + D[i]) % D[i];
                            end else if (t < 0) begin
                                t = 0;
                                m_err[i] = 1'b1;
                            end else if (t >= D[i]) begin
                                t = D[i] - 1;
                                m_err[i] = 1'b1;
                            end
                            m_addr[i] = t;
                        end
                        3'd5: m_addr[i] = 0;
                        3'd6: begin
                            for (int c = 0; c < 64; c++) m_mem[i][c] = 8'h00;
                            m_addr[i] = 0;
                            m_busy[i] = D[i];
                        end
                        3'd7: m_err[i] = 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------- comparison helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("d%0d_ready", i), 32'(rdy[i]), 32'(m_busy[i] == 0));
                chk($sformatf("d%0d_addr", i), 32'(adr[i]), 32'(m_addr[i]));
                chk($sformatf("d%0d_range_error", i), 32'(er[i]), 32'(m_err[i]));
                if (m_busy[i] == 0) begin
                    chk($sformatf("d%0d_value", i), 32'(val[i]), 32'(m_mem[i][m_addr[i]]));
                    chk($sformatf("d%0d_is_zero", i), 32'(zr[i]),
                        32'(m_mem[i][m_addr[i]] == 8'h00));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [2:0] op, input logic [7:0] d);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int exp_edges);
        int n;
        n = 0;
        while (!rdy[0] && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 32'(n), 32'(exp_edges));
    endtask

    task automatic wait_both_idle();
        int n;
        n = 0;
        while (!(rdy[0] && rdy[1]) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) chk("idle_timeout", 32'(n), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_d%0d_ready", tag, i), 32'(rdy[i]), 32'd0);
            chk($sformatf("%s_d%0d_addr", tag, i), 32'(adr[i]), 32'd0);
            chk($sformatf("%s_d%0d_range_error", tag, i), 32'(er[i]), 32'd0);
        end
    endtask

    task automatic random_cmd();
        int r;
        cmd_valid = ($urandom_range(0, 99) < 80);
        r = $urandom_range(0, 99);
        if      (r < 3)  cmd_op = 3'd6;
        else if (r < 8)  cmd_op = 3'd7;
        else if (r < 12) cmd_op = 3'd0;
        else if (r < 15) cmd_op = 3'd5;
        else if (r < 35) cmd_op = 3'd1;
        else if (r < 60) cmd_op = 3'd2;
        else if (r < 80) cmd_op = 3'd3;
        else             cmd_op = 3'd4;
        if ((cmd_op == 3'd3 || cmd_op == 3'd4) && $urandom_range(0, 1) == 0)
            cmd_data = 8'($urandom_range(0, 3));
        else
            cmd_data = 8'($urandom_range(0, 255));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");

        // Reserved op held through INIT must be ignored.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd7;
        rst_n     = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("init_busy_ready", 32'(rdy[0]), 32'd0);
        chk("init_no_error", 32'(er[0]), 32'd0);
        cmd_valid = 1'b0;
        wait_ready("init_latency", 24);
        chk("init_addr", 32'(adr[0]), 32'd0);
        chk("init_value", 32'(val[0]), 32'd0);
        chk("init_is_zero", 32'(zr[0]), 32'd1);
        wait_both_idle();

        for (int k = 1; k < 64; k++) begin
            issue(3'd3, 8'd1);
            chk("scan_addr", 32'(adr[0]), 32'(k));
            chk("scan_value", 32'(val[0]), 32'd0);
        end
        issue(3'd5, 8'd0);

        issue(3'd1, 8'h05);
        chk("set5", 32'(val[0]), 32'h05);
        for (int k = 4; k >= 0; k--) begin
            issue(3'd2, 8'hFF);
            chk("dec_value", 32'(val[0]), 32'(k));
            chk("dec_is_zero", 32'(zr[0]), 32'(k == 0));
        end
        issue(3'd2, 8'hFF);
        chk("dec_underflow", 32'(val[0]), 32'hFF);
        chk("dec_underflow_zero", 32'(zr[0]), 32'd0);
        issue(3'd2, 8'h01);
        chk("inc_overflow", 32'(val[0]), 32'h00);

        issue(3'd5, 8'd0);
        issue(3'd3, 8'd60);
        chk("movr60_addr", 32'(adr[0]), 32'd60);
        chk("movr60_err", 32'(er[0]), 32'd0);
        issue(3'd3, 8'd10);
        chk("clamp_right_addr", 32'(adr[0]), 32'd63);
        chk("clamp_right_err", 32'(er[0]), 32'd1);
        chk("wrap_right_addr", 32'(adr[1]), 32'd22);
        issue(3'd0, 8'd0);
        chk("err_pulse_end", 32'(er[0]), 32'd0);
        issue(3'd4, 8'd200);
        chk("clamp_left_addr", 32'(adr[0]), 32'd0);
        chk("clamp_left_err", 32'(er[0]), 32'd1);
        chk("wrap_left_big", 32'(adr[1]), 32'd14);
        chk("wrap_no_err", 32'(er[1]), 32'd0);

        issue(3'd5, 8'd0);
        issue(3'd3, 8'd40);
        issue(3'd3, 8'd10);
        chk("wrap40_plus10", 32'(adr[1]), 32'd2);
        issue(3'd4, 8'd5);
        chk("wrap2_minus5", 32'(adr[1]), 32'd45);
        chk("clamp_inrange_left", 32'(adr[0]), 32'd45);

        issue(3'd5, 8'd0);
        for (int k = 0; k < 4; k++) begin
            issue(3'd1, 8'(8'h11 * (k + 1)));
            if (k < 3) issue(3'd3, 8'd1);
        end
        issue(3'd5, 8'd0);
        chk("rollback_addr", 32'(adr[0]), 32'd0);
        chk("rollback_cell0", 32'(val[0]), 32'h11);
        issue(3'd3, 8'd3);
        chk("rollback_cell3", 32'(val[0]), 32'h44);
        issue(3'd6, 8'd0);
        chk("clear_ready_low", 32'(rdy[0]), 32'd0);
        chk("clear_addr", 32'(adr[0]), 32'd0);
        wait_ready("clear_latency", 64);
        chk("clear_cell0", 32'(val[0]), 32'd0);
        wait_both_idle();
        issue(3'd3, 8'd3);
        chk("clear_cell3", 32'(val[0]), 32'd0);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            random_cmd();
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_both_idle();

        // Reset in the middle of a CLEAR sweep.
        issue(3'd6, 8'd0);
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midclear");
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("midclear_reinit", 64);
        wait_both_idle();

        // Reset during a back-to-back command burst.
        issue(3'd3, 8'd7);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            random_cmd();
            cmd_valid = 1'b1;
            if (cmd_op == 3'd6) cmd_op = 3'd2;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midburst");
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("midburst_reinit", 64);
        wait_both_idle();
        issue(3'd0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/bf_tape_memory.md
Name: bf_tape_memory

Overview:
Parametrised Brainfuck data tape: DEPTH cells of CELL_WIDTH bits, addressed by a data pointer, driven by a valid/ready command interface from the interpreter core. Adds in-place ADD, multi-cell moves, optional wrap-around, a range-error flag and a full-tape CLEAR sweep. Sits between the instruction decoder and the output/monitor logic; the pointed-to cell is always visible on ptr_value.

Parameters:
CELL_WIDTH, 8, bits per tape cell
DEPTH, 64, number of cells; 2 <= DEPTH <= 2**ADDR_WIDTH
ADDR_WIDTH, 6, pointer width
WRAP, 0, 1 = pointer wraps modulo DEPTH; 0 = pointer clamps at the ends and flags range_error

Ports:
working_clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_op  in  3  0 NOP, 1 SET, 2 ADD, 3 MOVR, 4 MOVL, 5 ROLLBACK, 6 CLEAR, 7 reserved
cmd_data  in  CELL_WIDTH  SET value, ADD addend, or MOVR/MOVL step count (zero-extended)
cmd_ready  out  1  block accepts a command this cycle
ptr_value  out  CELL_WIDTH  mem[address], combinational read
ptr_address  out  ADDR_WIDTH  current pointer
ptr_is_zero  out  1  ptr_value == 0; used for [ ] branching
range_error  out  1  one-cycle pulse on a clamped move or reserved op

Behaviour:
- Storage is a register array with no reset. Contents after reset are defined only by the INIT sweep.
- reset_n low, asynchronous: state=INIT, address=0, sweep_idx=0, cmd_ready=0, range_error=0. Reset mid-operation, including mid-CLEAR, abandons the operation and restarts INIT.
- States:
  - INIT: each cycle writes mem[sweep_idx]=0 and increments sweep_idx. After the write to DEPTH-1, goes to IDLE. cmd_ready=0.
    - First command can be accepted on cycle DEPTH+1 after reset release.
  - IDLE: cmd_ready=1. A command is accepted when cmd_valid && cmd_ready. All ops except CLEAR complete at that same clock edge, so throughput is one command per cycle.
  - CLEAR: same sweep as INIT, entered from IDLE. address=0 on entry. cmd_ready=0 for DEPTH cycles, then IDLE.
- SET: mem[address] <= cmd_data.
- ADD: mem[address] <= mem[address] + cmd_data, mod 2**CELL_WIDTH.
  - Decrement is ADD of all-ones, e.g. 8'hFF.
  - 0 + 8'hFF gives 8'hFF.
  - 8'hFF + 1 gives 0.
- MOVR/MOVL by n = cmd_data:
  - n = 0 behaves as NOP.
  - Target = address +/- n, computed at ADDR_WIDTH+CELL_WIDTH+1 bits to avoid overflow.
  - WRAP=1: address <= target mod DEPTH. Handles DEPTH not a power of two and n >= DEPTH. No error.
  - WRAP=0, target in range: address <= target.
  - WRAP=0, target out of range: address <= DEPTH-1 (right) or 0 (left), and range_error pulses for one cycle.
- ROLLBACK: address <= 0 in one cycle. Memory untouched.
- NOP: no state change.
- Reserved op 7: no state change, range_error pulses for one cycle.
- cmd_valid while cmd_ready=0: ignored. The command is not latched; the producer must hold it.
- ptr_value, ptr_address and ptr_is_zero reflect the updated state in the cycle after the accepting edge.
- range_error is registered, default 0, and high only in the cycle after the offending accept.

Test Plan:
- Reset release (DEPTH=64) -> cmd_ready low for 64 cycles, then high; ptr_address=0, ptr_value=0, ptr_is_zero=1; reads at all 64 addresses (via MOVR 1 steps) return 0.
- SET 8'h05, ADD 8'hFF x5, ADD 8'hFF -> ptr_value 5,4,3,2,1,0,8'hFF; ptr_is_zero=1 only at 0.
- WRAP=0: MOVR 60 then MOVR 10 -> ptr_address 60 then 63, range_error=1 one cycle; MOVL 200 -> ptr_address 0, range_error pulse. WRAP=1, DEPTH=48: at 40, MOVR 10 -> 2; MOVL 5 -> 45.
- Write distinct values at cells 0..3, ROLLBACK -> ptr_address 0, cells intact; CLEAR -> cmd_ready low 64 cycles, all cells 0, address 0.
- Assert reset_n low mid-CLEAR (sweep_idx=20) and mid-burst of back-to-back commands -> outputs return to reset values immediately; full INIT sweep reruns.
- cmd_op=7 and cmd_valid held during INIT -> op 7 gives range_error pulse with no state change; commands during INIT are not executed.
